// File: rtl/memory_s_dp_pkg.sv
// memory_s_dp_pkg
//   Shared definitions for the parametrised simple dual-port SRAM model:
//   collision-mode selectors, the clear sequencer state encoding and the
//   byte-lane merge used to build write-first read data.
package memory_s_dp_pkg;

  // Values for the COLLISION_MODE parameter of memory_s_dp_param.
  localparam int COLLISION_READ_FIRST  = 0;  // same-address read returns old word
  localparam int COLLISION_WRITE_FIRST = 1;  // same-address read returns merged word

  // Clear sequencer states. IDLE is only occupied while reset is held.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    READY = 2'd2
  } clear_state_t;

  // Merge of one byte lane: the new byte replaces the old one only when the
  // lane's write enable is set. Callers apply it lane by lane so the same
  // function serves any DATA_WIDTH.
  function automatic logic [7:0] byte_merge(
    input logic [7:0] old_byte,
    input logic [7:0] new_byte,
    input logic       enable
  );
    return enable ? new_byte : old_byte;
  endfunction

endpackage

// File: rtl/memory_s_dp_clear_seq.sv
// memory_s_dp_clear_seq
//   Post-reset sequencer. With CLEAR_ON_RESET=1 it walks an ADDR_WIDTH
//   counter over every word, asking the top to write zero at each address,
//   and only then raises sram_ready. With CLEAR_ON_RESET=0 it goes straight
//   from IDLE to READY on the first edge after reset release.
// Ports:
//   sram_clock     in   clock, rising edge
//   sram_reset_n   in   synchronous active-low reset
//   clear_write    out  request to write an all-zero word this cycle
//   clear_address  out  word address for clear_write
//   sram_ready     out  high once the memory accepts requests
//   clear_state    out  current sequencer state (debug visibility)
module memory_s_dp_clear_seq
  import memory_s_dp_pkg::*;
#(
  parameter int ADDR_WIDTH     = 11,
  parameter int CLEAR_ON_RESET = 0
) (
  input  logic                  sram_clock,
  input  logic                  sram_reset_n,
  output logic                  clear_write,
  output logic [ADDR_WIDTH-1:0] clear_address,
  output logic                  sram_ready,
  output clear_state_t          clear_state
);

  clear_state_t          state_q, state_d;
  logic [ADDR_WIDTH-1:0] count_q, count_d;

  always_ff @(posedge sram_clock) begin
    if (!sram_reset_n) begin
      state_q <= IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    clear_write = 1'b0;
    case (state_q)
      IDLE: begin
        count_d = '0;
        state_d = (CLEAR_ON_RESET != 0) ? CLEAR : READY;
      end
      CLEAR: begin
        // One zero word per cycle; the last address is written on the same
        // edge that moves to READY, so CLEAR lasts exactly DEPTH cycles.
        clear_write = 1'b1;
        count_d     = count_q + 1'b1;
        if (count_q == {ADDR_WIDTH{1'b1}}) begin
          state_d = READY;
        end
      end
      READY: begin
        state_d = READY;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign clear_address = count_q;
  assign sram_ready    = (state_q == READY);
  assign clear_state   = state_q;

endmodule

// File: rtl/memory_s_dp_param.sv
// memory_s_dp_param
//   Simple dual-port synchronous SRAM emulation model: one read port, one
//   write port, one clock. Byte write enables, read latency 1 or 2,
//   selectable same-address collision behaviour, read-valid strobe and an
//   optional clear-to-zero pass after reset.
// Handshake: sram_ready is the only flow control. A read or write counts
//   when its request bit is high at a rising edge where sram_ready is high
//   and sram_reset_n is high; requests at any other edge are dropped with no
//   side effects. There is no per-request acknowledge; every accepted read
//   produces exactly one sram_read_data_valid pulse READ_LATENCY cycles later.
// Ports:
//   sram_clock, sram_reset_n      clock and synchronous active-low reset
//   sram_ready                    high when requests are accepted
//   sram_read, sram_read_address  read request and word address
//   sram_read_data                read data, holds between reads
//   sram_read_data_valid          one-cycle strobe per accepted read
//   sram_write, sram_write_address, sram_write_data,
//   sram_write_byte_enables       write request, address, data, lane enables
//   clear_state                   clear sequencer state (debug visibility)
module memory_s_dp_param
  import memory_s_dp_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 11,
  parameter int READ_LATENCY   = 1,
  parameter int COLLISION_MODE = COLLISION_READ_FIRST,
  parameter int CLEAR_ON_RESET = 0
) (
  input  logic                    sram_clock,
  input  logic                    sram_reset_n,
  output logic                    sram_ready,
  input  logic                    sram_read,
  input  logic [ADDR_WIDTH-1:0]   sram_read_address,
  output logic [DATA_WIDTH-1:0]   sram_read_data,
  output logic                    sram_read_data_valid,
  input  logic                    sram_write,
  input  logic [ADDR_WIDTH-1:0]   sram_write_address,
  input  logic [DATA_WIDTH-1:0]   sram_write_data,
  input  logic [DATA_WIDTH/8-1:0] sram_write_byte_enables,
  output clear_state_t            clear_state
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int BYTES = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  clear_write;
  logic [ADDR_WIDTH-1:0] clear_address;

  logic                  read_accept;
  logic                  write_accept;
  logic                  collide;
  logic [DATA_WIDTH-1:0] read_word;
  logic [DATA_WIDTH-1:0] merged_word;
  logic [DATA_WIDTH-1:0] read_next;

  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [BYTES-1:0]      wr_be;

  logic                  s1_valid;
  logic [DATA_WIDTH-1:0] s1_data;

  memory_s_dp_clear_seq #(
    .ADDR_WIDTH     (ADDR_WIDTH),
    .CLEAR_ON_RESET (CLEAR_ON_RESET)
  ) u_clear_seq (
    .sram_clock    (sram_clock),
    .sram_reset_n  (sram_reset_n),
    .clear_write   (clear_write),
    .clear_address (clear_address),
    .sram_ready    (sram_ready),
    .clear_state   (clear_state)
  );

  // sram_ready only falls on the edge after reset is sampled, so reset is
  // also folded in here to keep the reset edge itself free of side effects.
  assign read_accept  = sram_read  && sram_ready && sram_reset_n;
  assign write_accept = sram_write && sram_ready && sram_reset_n;

  // Clear writes and user writes never overlap: sram_ready is low for the
  // whole clear pass, so user writes are already rejected then.
  always_comb begin
    wr_en   = write_accept;
    wr_addr = sram_write_address;
    wr_data = sram_write_data;
    wr_be   = sram_write_byte_enables;
    if (clear_write) begin
      wr_en   = 1'b1;
      wr_addr = clear_address;
      wr_data = '0;
      wr_be   = '1;
    end
  end

  always_ff @(posedge sram_clock) begin
    if (wr_en) begin
      for (int i = 0; i < BYTES; i++) begin
        if (wr_be[i]) begin
          mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
        end
      end
    end
  end

  // Write-first read data: the word as it will look after this edge's write.
  assign read_word = mem[sram_read_address];

  for (genvar i = 0; i < BYTES; i++) begin : g_merge
    assign merged_word[8*i +: 8] = byte_merge(read_word[8*i +: 8],
                                              sram_write_data[8*i +: 8],
                                              sram_write_byte_enables[i]);
  end

  // Read-first needs no bypass: the array read above sees the pre-edge word.
  assign collide   = (COLLISION_MODE == COLLISION_WRITE_FIRST) && read_accept &&
                     write_accept && (sram_read_address == sram_write_address);
  assign read_next = collide ? merged_word : read_word;

  // Stage 1: registered array read. Data only loads on an accepted read so
  // the output holds its last value between reads.
  always_ff @(posedge sram_clock) begin
    if (!sram_reset_n) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
    end else begin
      s1_valid <= read_accept;
      if (read_accept) begin
        s1_data <= read_next;
      end
    end
  end

  if (READ_LATENCY == 2) begin : g_lat2
    logic                  s2_valid;
    logic [DATA_WIDTH-1:0] s2_data;

    always_ff @(posedge sram_clock) begin
      if (!sram_reset_n) begin
        s2_valid <= 1'b0;
        s2_data  <= '0;
      end else begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2_data <= s1_data;
        end
      end
    end

    assign sram_read_data       = s2_data;
    assign sram_read_data_valid = s2_valid;
  end else begin : g_lat1
    assign sram_read_data       = s1_data;
    assign sram_read_data_valid = s1_valid;
  end

endmodule

// File: tb/tb_memory_s_dp_param.sv
// tb_memory_s_dp_param
//   Two instances share one clock:
//     a: defaults (32x2048, latency 1, read-first, no clear)
//     b: 32x16, latency 2, write-first, clear on reset
//   Reads push {due_cycle, data} to a per-instance expected queue; every
//   tick pops and compares whatever the DUT presents.
module tb_memory_s_dp_param;
  import memory_s_dp_pkg::*;

  localparam int A_LAT  = 1;
  localparam int A_MODE = 0;
  localparam int B_LAT  = 2;
  localparam int B_MODE = 1;

  // ---------------- clock / reset ----------------
  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic         a_reset_n, a_ready, a_read, a_rvalid, a_write;
  logic [10:0]  a_raddr, a_waddr;
  logic [31:0]  a_rdata, a_wdata;
  logic [3:0]   a_be;
  clear_state_t a_state;

  logic         b_reset_n, b_ready, b_read, b_rvalid, b_write;
  logic [3:0]   b_raddr, b_waddr;
  logic [31:0]  b_rdata, b_wdata;
  logic [3:0]   b_be;
  clear_state_t b_state;

  memory_s_dp_param u_a (
    .sram_clock              (clk),
    .sram_reset_n            (a_reset_n),
    .sram_ready              (a_ready),
    .sram_read               (a_read),
    .sram_read_address       (a_raddr),
    .sram_read_data          (a_rdata),
    .sram_read_data_valid    (a_rvalid),
    .sram_write              (a_write),
    .sram_write_address      (a_waddr),
    .sram_write_data         (a_wdata),
    .sram_write_byte_enables (a_be),
    .clear_state             (a_state)
  );

  memory_s_dp_param #(
    .DATA_WIDTH     (32),
    .ADDR_WIDTH     (4),
    .READ_LATENCY   (B_LAT),
    .COLLISION_MODE (B_MODE),
    .CLEAR_ON_RESET (1)
  ) u_b (
    .sram_clock              (clk),
    .sram_reset_n            (b_reset_n),
    .sram_ready              (b_ready),
    .sram_read               (b_read),
    .sram_read_address       (b_raddr),
    .sram_read_data          (b_rdata),
    .sram_read_data_valid    (b_rvalid),
    .sram_write              (b_write),
    .sram_write_address      (b_waddr),
    .sram_write_data         (b_wdata),
    .sram_write_byte_enables (b_be),
    .clear_state             (b_state)
  );

  // ---------------- scoreboard state ----------------
  logic [63:0] exp_q_a[$];
  logic [63:0] exp_q_b[$];
  logic [31:0] ref_a [2048];
  logic [31:0] ref_b [16];
  logic [31:0] cyc;
  int          vectors;
  int          misc;

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] be);
    logic [31:0] r;
    for (int k = 0; k < 4; k++) r[8*k +: 8] = be[k] ? n[8*k +: 8] : o[8*k +: 8];
    return r;
  endfunction

  // One clock: scoreboard check at the falling edge, then advance past the
  // next rising edge.
  task automatic tick();
    logic [63:0] e;
    @(negedge clk);
    if (a_rvalid === 1'b1) begin
      vectors++;
      if (exp_q_a.size() == 0) begin
        misc++;
        $display("FAIL a_unexpected_valid cyc=%0d data=%h expected no valid", cyc, a_rdata);
      end else begin
        e = exp_q_a.pop_front();
        if ({cyc, a_rdata} !== e) begin
          misc++;
          $display("FAIL a_read cyc=%0d data=%h expected cyc=%0d data=%h",
                   cyc, a_rdata, e[63:32], e[31:0]);
        end
      end
    end else if (exp_q_a.size() != 0 && exp_q_a[0][63:32] <= cyc) begin
      vectors++;
      misc++;
      e = exp_q_a.pop_front();
      $display("FAIL a_missed_valid cyc=%0d valid=%b expected valid data=%h",
               cyc, a_rvalid, e[31:0]);
    end
    if (b_rvalid === 1'b1) begin
      vectors++;
      if (exp_q_b.size() == 0) begin
        misc++;
        $display("FAIL b_unexpected_valid cyc=%0d data=%h expected no valid", cyc, b_rdata);
      end else begin
        e = exp_q_b.pop_front();
        if ({cyc, b_rdata} !== e) begin
          misc++;
          $display("FAIL b_read cyc=%0d data=%h expected cyc=%0d data=%h",
                   cyc, b_rdata, e[63:32], e[31:0]);
        end
      end
    end else if (exp_q_b.size() != 0 && exp_q_b[0][63:32] <= cyc) begin
      vectors++;
      misc++;
      e = exp_q_b.pop_front();
      $display("FAIL b_missed_valid cyc=%0d valid=%b expected valid data=%h",
               cyc, b_rvalid, e[31:0]);
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle_a(input logic rd, input logic [10:0] ra, input logic wr,
                         input logic [10:0] wa, input logic [31:0] wd, input logic [3:0] be);
    logic [31:0] x;
    a_read = rd; a_raddr = ra; a_write = wr; a_waddr = wa; a_wdata = wd; a_be = be;
    if (a_ready === 1'b1) begin
      if (rd) begin
        x = ref_a[ra];
        if (wr && wa == ra && A_MODE == 1) x = merge(x, wd, be);
        exp_q_a.push_back({cyc + 32'(A_LAT), x});
      end
      if (wr) ref_a[wa] = merge(ref_a[wa], wd, be);
    end
    tick();
    a_read = 1'b0; a_write = 1'b0;
  endtask

  task automatic cycle_b(input logic rd, input logic [3:0] ra, input logic wr,
                         input logic [3:0] wa, input logic [31:0] wd, input logic [3:0] be);
    logic [31:0] x;
    b_read = rd; b_raddr = ra; b_write = wr; b_waddr = wa; b_wdata = wd; b_be = be;
    if (b_ready === 1'b1) begin
      if (rd) begin
        x = ref_b[ra];
        if (wr && wa == ra && B_MODE == 1) x = merge(x, wd, be);
        exp_q_b.push_back({cyc + 32'(B_LAT), x});
      end
      if (wr) ref_b[wa] = merge(ref_b[wa], wd, be);
    end
    tick();
    b_read = 1'b0; b_write = 1'b0;
  endtask

  task automatic wr_a(input logic [10:0] a, input logic [31:0] d, input logic [3:0] be);
    cycle_a(1'b0, '0, 1'b1, a, d, be);
  endtask
  task automatic rd_a(input logic [10:0] a);
    cycle_a(1'b1, a, 1'b0, '0, '0, '0);
  endtask
  task automatic wr_b(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
    cycle_b(1'b0, '0, 1'b1, a, d, be);
  endtask
  task automatic rd_b(input logic [3:0] a);
    cycle_b(1'b1, a, 1'b0, '0, '0, '0);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && (exp_q_a.size() != 0 || exp_q_b.size() != 0); i++) tick();
    vectors++;
    if (exp_q_a.size() != 0) begin
      misc++;
      $display("FAIL a_drain pending=%0d expected 0", exp_q_a.size());
    end
    vectors++;
    if (exp_q_b.size() != 0) begin
      misc++;
      $display("FAIL b_drain pending=%0d expected 0", exp_q_b.size());
    end
  endtask

  task automatic wait_ready_b();
    for (int i = 0; i < 40 && b_ready !== 1'b1; i++) tick();
    vectors++;
    if (b_ready !== 1'b1) begin
      misc++;
      $display("FAIL b_ready_timeout ready=%b expected 1", b_ready);
    end
    for (int i = 0; i < 16; i++) ref_b[i] = '0;
  endtask

  // Counts cycles with b_ready low after a release edge; held read requests
  // during that window must not produce a valid.
  task automatic count_clear_b(input string name);
    int n;
    n = 0;
    b_reset_n = 1'b1;
    b_read    = 1'b1;
    b_raddr   = 4'($urandom_range(0, 15));
    for (int i = 0; i < 40; i++) begin
      tick();
      if (b_ready === 1'b1) break;
      n++;
    end
    b_read = 1'b0;
    vectors++;
    if (n != 16) begin
      misc++;
      $display("FAIL %s cycles_not_ready=%0d expected 16", name, n);
    end
    for (int i = 0; i < 16; i++) ref_b[i] = '0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    a_reset_n = 1'b0; b_reset_n = 1'b0;
    repeat (3) tick();
    vectors++; if (a_ready !== 1'b0) begin misc++; $display("FAIL reset_a_ready got=%b exp=0", a_ready); end
    vectors++; if (a_rvalid !== 1'b0) begin misc++; $display("FAIL reset_a_valid got=%b exp=0", a_rvalid); end
    vectors++; if (a_rdata !== 32'h0) begin misc++; $display("FAIL reset_a_data got=%h exp=0", a_rdata); end
    vectors++; if (a_state !== IDLE) begin misc++; $display("FAIL reset_a_state got=%0d exp=%0d", a_state, IDLE); end
    vectors++; if (b_ready !== 1'b0) begin misc++; $display("FAIL reset_b_ready got=%b exp=0", b_ready); end
    vectors++; if (b_rdata !== 32'h0) begin misc++; $display("FAIL reset_b_data got=%h exp=0", b_rdata); end
    a_reset_n = 1'b1; b_reset_n = 1'b1;
    tick();
    vectors++; if (a_ready !== 1'b1) begin misc++; $display("FAIL release_a_ready got=%b exp=1", a_ready); end
    vectors++; if (b_state !== CLEAR) begin misc++; $display("FAIL release_b_state got=%0d exp=%0d", b_state, CLEAR); end
    wait_ready_b();
  endtask

  task automatic test_basic();
    wr_a(11'd5, 32'hDEADBEEF, 4'hF);
    rd_a(11'd5);
    tick();
    vectors++; if (a_rvalid !== 1'b0) begin misc++; $display("FAIL basic_idle_valid got=%b exp=0", a_rvalid); end
    vectors++; if (a_rdata !== 32'hDEADBEEF) begin misc++; $display("FAIL basic_hold got=%h exp=deadbeef", a_rdata); end
    tick();
    vectors++; if (a_rdata !== 32'hDEADBEEF) begin misc++; $display("FAIL basic_hold2 got=%h exp=deadbeef", a_rdata); end
    wr_a(11'd0, 32'h0BAD0000, 4'hF);
    wr_a(11'd2047, 32'h0000F00D, 4'hF);
    rd_a(11'd2047);
    rd_a(11'd0);
    drain();
  endtask

  task automatic test_byte_enables();
    wr_a(11'd7, 32'h11223344, 4'hF);
    wr_a(11'd7, 32'hAABBCCDD, 4'b0101);
    wr_a(11'd7, 32'hFFFFFFFF, 4'b0000);
    rd_a(11'd7);
    drain();
    vectors++; if (a_rdata !== 32'h11BB33DD) begin misc++; $display("FAIL byte_enables got=%h exp=11bb33dd", a_rdata); end
  endtask

  task automatic test_collision();
    wr_a(11'd3, 32'h0, 4'hF);
    cycle_a(1'b1, 11'd3, 1'b1, 11'd3, 32'h12345678, 4'hF);
    rd_a(11'd3);
    wr_a(11'd9, 32'h11223344, 4'hF);
    cycle_a(1'b1, 11'd9, 1'b1, 11'd9, 32'hAABBCCDD, 4'b0011);
    rd_a(11'd9);
    wr_b(4'd3, 32'h0, 4'hF);
    cycle_b(1'b1, 4'd3, 1'b1, 4'd3, 32'h12345678, 4'hF);
    rd_b(4'd3);
    wr_b(4'd9, 32'h11223344, 4'hF);
    cycle_b(1'b1, 4'd9, 1'b1, 4'd9, 32'hAABBCCDD, 4'b0011);
    rd_b(4'd9);
    cycle_b(1'b1, 4'd1, 1'b1, 4'd9, 32'h55555555, 4'hF);
    drain();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 16; i++) wr_a(11'(64 + i), $urandom, 4'hF);
    for (int i = 0; i < 40; i++)
      cycle_a(1'b1, 11'(64 + $urandom_range(0, 15)), 1'($urandom_range(0, 1)),
              11'(64 + $urandom_range(0, 15)), $urandom, 4'($urandom_range(0, 15)));
    drain();
  endtask

  task automatic test_latency2_stream();
    wr_b(4'd0, 32'hA0, 4'hF);
    wr_b(4'd1, 32'hA1, 4'hF);
    wr_b(4'd2, 32'hA2, 4'hF);
    rd_b(4'd0);
    rd_b(4'd1);
    rd_b(4'd2);
    drain();
  endtask

  task automatic test_clear();
    for (int i = 0; i < 16; i++) wr_b(4'(i), 32'hFFFFFFFF, 4'hF);
    b_reset_n = 1'b0;
    tick();
    count_clear_b("clear_ready");
    for (int i = 0; i < 16; i++) rd_b(4'(i));
    drain();
    for (int i = 0; i < 16; i++) wr_b(4'(i), 32'h5A5A5A5A, 4'hF);
    b_reset_n = 1'b0;
    tick();
    b_reset_n = 1'b1;
    repeat (8) tick();
    b_reset_n = 1'b0;
    tick();
    vectors++; if (b_state !== IDLE) begin misc++; $display("FAIL clear_abort_state got=%0d exp=%0d", b_state, IDLE); end
    count_clear_b("clear_restart");
    for (int i = 0; i < 16; i++) rd_b(4'(i));
    drain();
  endtask

  task automatic test_reset_pipeline();
    wr_b(4'd5, 32'hCAFEF00D, 4'hF);
    rd_b(4'd5);
    drain();
    vectors++; if (b_rdata !== 32'hCAFEF00D) begin misc++; $display("FAIL pipe_pre got=%h exp=cafef00d", b_rdata); end
    b_read = 1'b1; b_raddr = 4'd5;
    tick();
    b_read = 1'b0; b_reset_n = 1'b0;
    tick();
    vectors++; if (b_rvalid !== 1'b0) begin misc++; $display("FAIL pipe_valid got=%b exp=0", b_rvalid); end
    vectors++; if (b_rdata !== 32'h0) begin misc++; $display("FAIL pipe_data got=%h exp=0", b_rdata); end
    repeat (2) begin
      tick();
      vectors++; if (b_rvalid !== 1'b0) begin misc++; $display("FAIL pipe_valid_late got=%b exp=0", b_rvalid); end
    end
    b_reset_n = 1'b1;
    wait_ready_b();
    repeat (3) tick();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    cyc = '0; vectors = 0; misc = 0;
    a_reset_n = 1'b0; a_read = 1'b0; a_raddr = '0; a_write = 1'b0;
    a_waddr = '0; a_wdata = '0; a_be = '0;
    b_reset_n = 1'b0; b_read = 1'b0; b_raddr = '0; b_write = 1'b0;
    b_waddr = '0; b_wdata = '0; b_be = '0;
    #1;
    test_reset();
    test_basic();
    test_byte_enables();
    test_collision();
    test_back_to_back();
    test_latency2_stream();
    test_clear();
    test_reset_pipeline();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, misc);
    $finish;
  end

endmodule

// File: doc/memory_s_dp_param.md
Name: memory_s_dp_param

Overview:
- Parametrised simple dual-port synchronous SRAM emulation model; next generation of the fixed 2048x32 dual-port macros in the gip_ddr emulation macro library.
- One read port and one write port on a single clock.
- Adds byte write enables, selectable read latency (1 or 2), defined read/write collision behaviour, read-valid strobe and optional clear-on-reset sequencer.
- Instantiated wherever FPGA/emulation builds need on-chip RAM: descriptor stores, data FIFOs, register files.

Parameters:
- DATA_WIDTH, 32, word width in bits; must be a multiple of 8.
- ADDR_WIDTH, 11, address bits; DEPTH = 2**ADDR_WIDTH words.
- READ_LATENCY, 1, cycles from sampled read request to data/valid; legal values 1 or 2.
- COLLISION_MODE, 0, same-address read/write on same edge: 0 = read-first (old data), 1 = write-first (new merged data).
- CLEAR_ON_RESET, 0, 1 = zero every word after reset release before accepting requests.

Ports:
- sram_clock  in  1  single clock, rising edge.
- sram_reset_n  in  1  synchronous, active-low reset.
- sram_ready  out  1  high when requests are accepted.
- sram_read  in  1  read request.
- sram_read_address  in  ADDR_WIDTH  read word address.
- sram_read_data  out  DATA_WIDTH  read data; holds last value between reads.
- sram_read_data_valid  out  1  one-cycle strobe per accepted read.
- sram_write  in  1  write request.
- sram_write_address  in  ADDR_WIDTH  write word address.
- sram_write_data  in  DATA_WIDTH  write data.
- sram_write_byte_enables  in  DATA_WIDTH/8  per-byte write enable; bit i covers bits 8i+7:8i.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low. sram_reset_n is sampled at the rising edge of sram_clock.
- Reset values: sram_read_data=0, sram_read_data_valid=0, all pipeline valids=0. sram_ready=0 while in reset. Memory array is not reset.
- Ready after reset release, CLEAR_ON_RESET=0: sram_ready=1 from the first cycle after the first edge sampling sram_reset_n=1.
- Ready after reset release, CLEAR_ON_RESET=1: clear FSM runs IDLE(reset) -> CLEAR -> READY.
  - CLEAR writes all-zero words to addresses 0..DEPTH-1, one per cycle, using an ADDR_WIDTH counter.
  - Leaves CLEAR after writing DEPTH-1, i.e. DEPTH cycles.
  - sram_ready=0 throughout CLEAR; rises the cycle after the last clear write.
- Reset asserted mid-CLEAR: FSM returns to IDLE; the counter restarts from 0 on release.
- Request qualification: requests are accepted only at edges where sram_ready=1. When sram_ready=0, sram_read and sram_write are ignored: no array update, no valid strobe.
- Write: at an accepted edge, each byte lane with its enable set is updated. Byte lanes with enable=0 keep their old contents. Write with all enables 0 is a no-op.
- Read, READ_LATENCY=1: request sampled at edge E gives sram_read_data and sram_read_data_valid=1 in the cycle after E, driven from registers.
- Read, READ_LATENCY=2: request sampled at edge E gives data/valid in the cycle after E+1, through an extra output register.
- Back-to-back reads: one result per cycle, fully pipelined.
- Read data hold: sram_read_data keeps its last value when no valid is presented; sram_read_data_valid=0 in those cycles.
- Collision, read and write to the same address on the same accepted edge:
  - Mode 0 returns the pre-write word.
  - Mode 1 returns the post-write word, i.e. the byte-merge of old data and write data.
- Different-address simultaneous read/write: independent.
- Reset mid-read pipeline: in-flight reads are discarded; no valid is emitted after reset.
- Address range: every ADDR_WIDTH value is legal; there is no wrap or out-of-range case.

Decomposition:
- Shared package memory_s_dp_pkg holds:
  - COLLISION_READ_FIRST=0 and COLLISION_WRITE_FIRST=1;
  - clear FSM state encoding (IDLE, CLEAR, READY);
  - a byte-merge function (old, new, enables).
- Sub-module memory_s_dp_clear_seq contains the clear FSM plus address counter. It outputs clear_write, clear_address and sram_ready. The top muxes clear_write/clear_address in front of the write port.

Test Plan:
- Basic write/read, defaults: write 0xDEADBEEF to address 5 with enables 0xF; read address 5 next cycle -> data 0xDEADBEEF with valid=1 exactly one cycle after the read edge. Valid is 0 in the following idle cycle and data holds.
- Byte enables: preload 0x11223344 at address 7; write 0xAABBCCDD with enables 0b0101; read -> 0x11BB33DD.
- Collision: preload 0x0 at address 3; on the same edge write 0x12345678 (all enables) and read address 3. Mode 0 -> 0x00000000, mode 1 -> 0x12345678. A following read returns 0x12345678 in both modes.
- Latency 2 streaming: READ_LATENCY=2; reads of addresses 0,1,2 on consecutive edges with contents 0xA0,0xA1,0xA2 -> valid high for 3 consecutive cycles starting 2 cycles after the first read, data 0xA0,0xA1,0xA2 in order.
- Clear sequencer: CLEAR_ON_RESET=1, ADDR_WIDTH=4; fill RAM with 0xFF..; pulse reset.
  - sram_ready stays 0 for 16 cycles after release, then 1.
  - Reads issued during clear produce no valid.
  - After ready, all 16 addresses read 0.
  - A reset reasserted at clear cycle 8 restarts the 16-cycle count.
- Reset mid-pipeline: READ_LATENCY=2; issue a read, assert sram_reset_n=0 at the next edge -> valid never asserts, and data reads 0 after the reset edge.
